// File: rtl/instr_fetch_seq_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package instr_fetch_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    LD1  = 3'd2,
    RD2  = 3'd3,
    LD2  = 3'd4,
    HOLD = 3'd5
  } state_e;

  localparam logic [1:0] FETCH_NONE = 2'b00;
  localparam logic [1:0] FETCH_B1   = 2'b01;
  localparam logic [1:0] FETCH_B2   = 2'b10;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 5;

  // The opcode field of byte 1 selects a mask bit that marks two-byte instructions.
  function automatic logic is_two_byte(input logic [7:0] mask, input logic [7:0] byte1);
    return mask[byte1[OPC_MSB:OPC_LSB]];
  endfunction

endpackage

// File: rtl/instr_fetch_seq.sv
// Fetch sequencer: reads 1-2 instruction bytes from program memory, strobes them
// into the instruction register and holds instr_valid until execute consumes it.
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter int                ADDR_W        = 8,
  parameter logic [ADDR_W-1:0] RESET_PC      = '0,
  parameter logic [7:0]        TWO_BYTE_MASK = 8'hF0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        fetch,
  output logic [7:0]        data,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic [ADDR_W-1:0] pc,
  output state_e            dbg_state
);

  // Handshakes: mem_req stays high until a cycle with mem_ack=1 (which may be the
  // first req cycle); mem_ack outside a req is ignored. instr_valid stays high until
  // a cycle with instr_ready=1; instr_ready outside HOLD is ignored.

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        dbuf_q, dbuf_d;
  logic [7:0]        data_q, data_d;
  logic [1:0]        fetch_q, fetch_d;
  logic              mem_req_q, mem_req_d;
  logic              instr_valid_q, instr_valid_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    dbuf_d        = dbuf_q;
    data_d        = data_q;
    fetch_d       = FETCH_NONE;
    mem_req_d     = 1'b0;
    instr_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pc_load) pc_d = pc_load_val;
        if (en) state_d = RD1;
      end
      RD1, RD2: begin
        if (mem_ack) begin
          dbuf_d  = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = (state_q == RD1) ? LD1 : LD2;
        end
      end
      LD1:     state_d = is_two_byte(TWO_BYTE_MASK, dbuf_q) ? RD2 : HOLD;
      LD2:     state_d = HOLD;
      HOLD: begin
        if (instr_ready) begin
          if (pc_load) pc_d = pc_load_val;
          state_d = en ? RD1 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    mem_req_d     = (state_d == RD1) || (state_d == RD2);
    instr_valid_d = (state_d == HOLD);
    if (state_d == LD1) begin
      fetch_d = FETCH_B1;
      data_d  = dbuf_d;
    end else if (state_d == LD2) begin
      fetch_d = FETCH_B2;
      data_d  = dbuf_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      dbuf_q        <= '0;
      data_q        <= '0;
      fetch_q       <= FETCH_NONE;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      dbuf_q        <= dbuf_d;
      data_q        <= data_d;
      fetch_q       <= fetch_d;
      mem_req_q     <= mem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign fetch       = fetch_q;
  assign data        = data_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign dbg_state   = state_q;

endmodule
